cv32e40p_div_seq: RTL and testbench



---
 rtl/cv32e40p_pkg.sv | 25 ++
 rtl/cv32e40p_div_lzc.sv | 16 +
 rtl/cv32e40p_div_seq.sv | 168 ++++++++++++++++
 tb/tb_cv32e40p_div_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the EX-stage divider: opcode encoding, FSM states and a
// magnitude helper used when operands are captured.
package cv32e40p_pkg;

  // bit 1 selects remainder, bit 0 selects signed arithmetic
  typedef enum logic [1:0] {
    DIV_DIVU = 2'b00,
    DIV_DIV  = 2'b01,
    DIV_REMU = 2'b10,
    DIV_REM  = 2'b11
  } div_opcode_e;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_DIVIDE,
    DIV_FIX,
    DIV_FINISH
  } div_state_e;

  function automatic logic [31:0] div_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/cv32e40p_div_lzc.sv
// 32-bit leading-zero counter; returns 32 for an all-zero input.
// Only instantiated when CV32E40P_DIV_EARLY_EXIT_EN is defined.
module cv32e40p_div_lzc (
  input  logic [31:0] data_i,
  output logic [5:0]  lz_o
);

  // scan upward so the highest set bit determines the count
  always_comb begin
    lz_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) lz_o = 6'(31 - i);
    end
  end

endmodule

// File: rtl/cv32e40p_div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional macro CV32E40P_DIV_EARLY_EXIT_EN skips the dividend's leading zeros.
//
// state      | meaning
// DIV_IDLE   | ready for a new operation
// DIV_PREP   | load remainder/quotient registers and iteration counter
// DIV_DIVIDE | one quotient bit per cycle
// DIV_FIX    | apply result signs, select quotient or remainder
// DIV_FINISH | result valid, wait for ex_ready_i
module cv32e40p_div_seq
  import cv32e40p_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  div_opcode_e       operator_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              multicycle_o,
  output logic              ready_o,
  input  logic              ex_ready_i
);

  div_state_e  state_q, state_d;
  logic [31:0] a_abs_q, b_abs_q, rem_q, q_q, result_q;
  logic [4:0]  cnt_q;
  logic        q_neg_q, r_neg_q, is_rem_q;

  logic        accept, sgn, special;
  logic [31:0] a_abs, b_abs, special_res;
  logic [32:0] trial;

  assign result_o = result_q;
  assign sgn      = operator_i[0];
  assign a_abs    = div_abs(op_a_i, sgn);
  assign b_abs    = div_abs(op_b_i, sgn);

  // special cases resolved at accept, bypassing the iteration entirely
  always_comb begin
    special     = 1'b0;
    special_res = 32'd0;
    if (op_b_i == 32'd0) begin
      special     = 1'b1;
      special_res = operator_i[1] ? op_a_i : 32'hFFFF_FFFF;
    end else if (sgn && op_a_i == 32'h8000_0000 && op_b_i == 32'hFFFF_FFFF) begin
      special     = 1'b1;
      special_res = operator_i[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef CV32E40P_DIV_EARLY_EXIT_EN
    else if (a_abs == 32'd0) begin
      special     = 1'b1;
      special_res = 32'd0;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // next state and handshake outputs; flush overrides everything
  always_comb begin
    state_d      = state_q;
    ready_o      = 1'b0;
    multicycle_o = 1'b0;
    accept       = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        ready_o = 1'b1;
        if (enable_i && !flush_i) begin
          ready_o = 1'b0;
          accept  = 1'b1;
          state_d = special ? DIV_FINISH : DIV_PREP;
        end
      end
      DIV_PREP: begin
        multicycle_o = 1'b1;
        state_d      = DIV_DIVIDE;
      end
      DIV_DIVIDE: begin
        multicycle_o = 1'b1;
        if (cnt_q == 5'd0) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        multicycle_o = 1'b1;
        state_d      = DIV_FINISH;
      end
      DIV_FINISH: begin
        ready_o = 1'b1;
        if (ex_ready_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush_i) state_d = DIV_IDLE;
  end

  // trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    trial = {rem_q, q_q[31]} - {1'b0, b_abs_q};
  end

`ifdef CV32E40P_DIV_EARLY_EXIT_EN
  logic [5:0] lz;
  cv32e40p_div_lzc u_lzc (
    .data_i (a_abs_q),
    .lz_o   (lz)
  );
`endif

  // operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_abs_q  <= '0;
      b_abs_q  <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        a_abs_q  <= a_abs;
        b_abs_q  <= b_abs;
        q_neg_q  <= sgn & (op_a_i[31] ^ op_b_i[31]);
        r_neg_q  <= sgn & op_a_i[31];
        is_rem_q <= operator_i[1];
        if (special) result_q <= special_res;
      end
      case (state_q)
        DIV_PREP: begin
          rem_q <= '0;
`ifdef CV32E40P_DIV_EARLY_EXIT_EN
          q_q   <= a_abs_q << lz;
          cnt_q <= 5'(6'd31 - lz);
`else
          q_q   <= a_abs_q;
          cnt_q <= 5'd31;
`endif
        end
        DIV_DIVIDE: begin
          if (!trial[32]) begin
            rem_q <= trial[31:0];
            q_q   <= {q_q[30:0], 1'b1};
          end else begin
            rem_q <= {rem_q[30:0], q_q[31]};
            q_q   <= {q_q[30:0], 1'b0};
          end
          cnt_q <= cnt_q - 5'd1;
        end
        DIV_FIX: begin
          if (is_rem_q) result_q <= r_neg_q ? (32'd0 - rem_q) : rem_q;
          else          result_q <= q_neg_q ? (32'd0 - q_q) : q_q;
        end
        default: ;
      endcase
      if (flush_i) cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_cv32e40p_div_seq.sv
// Directed self-checking bench for cv32e40p_div_seq.
module tb_cv32e40p_div_seq;
  import cv32e40p_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  div_opcode_e operator_i = DIV_DIVU;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        flush_i = 1'b0;
  logic        ex_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        multicycle_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .operator_i   (operator_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .flush_i      (flush_i),
    .result_o     (result_o),
    .multicycle_o (multicycle_o),
    .ready_o      (ready_o),
    .ex_ready_i   (ex_ready_i)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait for ready_o; cycle 0 is the accept cycle.
  task automatic run_op(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res, input string name);
    int cyc;
    @(negedge clk);
    enable_i = 1'b1; operator_i = op; op_a_i = a; op_b_i = b;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL %s accept_ready got %b exp 0", name, ready_o);
    end
    @(posedge clk); #1;
    cyc = 1;
    @(negedge clk);
    enable_i = 1'b0; op_a_i = 32'hDEAD_BEEF; op_b_i = 32'h1234_5678; operator_i = DIV_REM;
    while (!ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat) begin
      errors++; $display("FAIL %s latency got %0d exp %0d", name, cyc, exp_lat);
    end
    checks++;
    if (result_o !== exp_res) begin
      errors++; $display("FAIL %s result got %h exp %h", name, result_o, exp_res);
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    ex_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1 || multicycle_o !== 1'b0) begin
      errors++; $display("FAIL %s consume got rdy=%b mc=%b exp rdy=1 mc=0", name, ready_o, multicycle_o);
    end
    @(negedge clk);
    ex_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ready_o !== 1'b1 || multicycle_o !== 1'b0 || result_o !== 32'd0) begin
      errors++; $display("FAIL reset got rdy=%b mc=%b res=%h exp 1 0 0", ready_o, multicycle_o, result_o);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1 || multicycle_o !== 1'b0 || result_o !== 32'd0) begin
      errors++; $display("FAIL post_reset got rdy=%b mc=%b res=%h exp 1 0 0", ready_o, multicycle_o, result_o);
    end
  endtask

  task automatic test_unsigned();
    run_op(DIV_DIVU, 32'd100, 32'd7, 35, 32'd14, "divu_100_7"); consume("divu_100_7");
    run_op(DIV_REMU, 32'd100, 32'd7, 35, 32'd2, "remu_100_7"); consume("remu_100_7");
    run_op(DIV_DIVU, 32'hFFFF_FFFF, 32'd16, 35, 32'h0FFF_FFFF, "divu_max_16"); consume("divu_max_16");
    run_op(DIV_REMU, 32'hFFFF_FFFF, 32'd16, 35, 32'h0000_000F, "remu_max_16"); consume("remu_max_16");
    run_op(DIV_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'd0, "divu_min_max"); consume("divu_min_max");
    run_op(DIV_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h8000_0000, "remu_min_max"); consume("remu_min_max");
  endtask

  task automatic test_signed();
    run_op(DIV_DIV, 32'hFFFF_FF9C, 32'd7, 35, 32'hFFFF_FFF2, "div_m100_7"); consume("div_m100_7");
    run_op(DIV_REM, 32'hFFFF_FF9C, 32'd7, 35, 32'hFFFF_FFFE, "rem_m100_7"); consume("rem_m100_7");
    run_op(DIV_DIV, 32'd100, 32'hFFFF_FFF9, 35, 32'hFFFF_FFF2, "div_100_m7"); consume("div_100_m7");
    run_op(DIV_REM, 32'd100, 32'hFFFF_FFF9, 35, 32'd2, "rem_100_m7"); consume("rem_100_m7");
  endtask

  task automatic test_div_zero();
    run_op(DIV_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "divu_by_zero"); consume("divu_by_zero");
    run_op(DIV_REM, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, "rem_by_zero"); consume("rem_by_zero");
  endtask

  task automatic test_overflow();
    run_op(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf"); consume("div_ovf");
    run_op(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "rem_ovf"); consume("rem_ovf");
  endtask

  task automatic test_hold();
    run_op(DIV_DIVU, 32'd100, 32'd7, 35, 32'd14, "hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_o !== 1'b1 || multicycle_o !== 1'b0 || result_o !== 32'd14) begin
        errors++; $display("FAIL hold_cycle%0d got rdy=%b mc=%b res=%h exp 1 0 0000000e", i, ready_o, multicycle_o, result_o);
      end
    end
    consume("hold");
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(DIV_DIVU, 32'd100, 32'd7, 35, 32'd14, "b2b_first");
    @(negedge clk);
    ex_ready_i = 1'b1; enable_i = 1'b1; operator_i = DIV_DIVU; op_a_i = 32'd9; op_b_i = 32'd3;
    @(posedge clk); #1;
    checks++;
    if (multicycle_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_not_taken got mc=%b rdy=%b exp mc=0 rdy=0", multicycle_o, ready_o);
    end
    @(negedge clk); ex_ready_i = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    checks++;
    if (multicycle_o !== 1'b1) begin
      errors++; $display("FAIL b2b_taken got mc=%b exp 1", multicycle_o);
    end
    @(negedge clk); enable_i = 1'b0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 35 || result_o !== 32'd3) begin
      errors++; $display("FAIL b2b_second got lat=%0d res=%h exp lat=35 res=00000003", cyc, result_o);
    end
    consume("b2b_second");
  endtask

  task automatic test_flush();
    run_op(DIV_DIVU, 32'd50, 32'd5, 35, 32'd10, "flush_prev"); consume("flush_prev");
    @(negedge clk);
    enable_i = 1'b1; operator_i = DIV_DIVU; op_a_i = 32'd1000; op_b_i = 32'd3;
    @(negedge clk); enable_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (multicycle_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd10) begin
      errors++; $display("FAIL flush_idle got mc=%b rdy=%b res=%h exp 0 1 0000000a", multicycle_o, ready_o, result_o);
    end
    @(negedge clk); flush_i = 1'b0;
    run_op(DIV_DIVU, 32'd9, 32'd3, 35, 32'd3, "after_flush"); consume("after_flush");
    @(negedge clk);
    enable_i = 1'b1; flush_i = 1'b1; operator_i = DIV_DIVU; op_a_i = 32'd8; op_b_i = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (multicycle_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd3) begin
      errors++; $display("FAIL flush_wins got mc=%b rdy=%b res=%h exp 0 1 00000003", multicycle_o, ready_o, result_o);
    end
    @(negedge clk); enable_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (multicycle_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd3) begin
      errors++; $display("FAIL flush_wins_after got mc=%b rdy=%b res=%h exp 0 1 00000003", multicycle_o, ready_o, result_o);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    enable_i = 1'b1; operator_i = DIV_DIVU; op_a_i = 32'd100; op_b_i = 32'd7;
    @(negedge clk); enable_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || multicycle_o !== 1'b0 || result_o !== 32'd0) begin
      errors++; $display("FAIL async_reset got rdy=%b mc=%b res=%h exp 1 0 0", ready_o, multicycle_o, result_o);
    end
    @(negedge clk); rst = 1'b0;
    run_op(DIV_REMU, 32'd100, 32'd7, 35, 32'd2, "after_reset"); consume("after_reset");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
